multi_counter: RTL and testbench
================================

Name: multi_counter

Overview:
Parametrised bank of NUM_CH independent up/down counters. Each channel has enable, direction, synchronous load and a programmable modulus. A global mode selects wrap or saturate at the bounds. The block also produces a registered sum of all channel values and per-channel sticky boundary-event flags. It replaces hand-instantiated free-running counter pairs summed combinationally.

Parameters:
WIDTH, 10, bits per channel counter
NUM_CH, 2, number of counter channels (>=1)
MAX_VAL, 2**WIDTH-1, upper count bound; the range is 0..MAX_VAL (must be >=1 and <=2**WIDTH-1)
SUM_W, WIDTH+$clog2(NUM_CH), localparam; width of the sum output

Ports:
clk  in  1  sole clock; all logic on posedge
rst  in  1  synchronous, active-high reset
en  in  NUM_CH  per-channel count enable
up  in  NUM_CH  per-channel direction: 1 = increment, 0 = decrement
load  in  NUM_CH  per-channel synchronous load strobe
load_val  in  NUM_CH*WIDTH  load values; channel i occupies [i*WIDTH +: WIDTH]
sat_mode  in  1  1 = saturate at bounds, 0 = wrap modulo MAX_VAL+1
evt_clr  in  1  clears all sticky event flags
cnt  out  NUM_CH*WIDTH  registered channel values, packed as load_val
sum  out  SUM_W  registered sum of all channel values
evt  out  NUM_CH  sticky boundary-event flags

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: cnt=0 for all channels, sum=0, evt=0. A reset mid-operation overrides load, en and evt_clr in that cycle.
- Per-channel priority each posedge: rst > load > en > hold.
- Load: cnt_i <= min(load_val_i, MAX_VAL). Load never sets evt_i.
- Count (en_i=1, load_i=0):
  - Up, cnt_i<MAX_VAL: cnt_i+1.
  - Up, cnt_i==MAX_VAL: wrap mode gives 0; saturate mode holds MAX_VAL.
  - Down, cnt_i>0: cnt_i-1.
  - Down, cnt_i==0: wrap mode gives MAX_VAL; saturate mode holds 0.
  - A boundary hit in either mode sets evt_i in the same edge.
- sat_mode is sampled every cycle. Changing it affects only the current edge's boundary decision, with no other state.
- evt: set has priority over evt_clr in the same cycle. Otherwise evt_clr=1 clears every flag on the next edge.
- sum: registered, 1-cycle latency. sum(t+1) = Σ cnt_i(t), where cnt is the registered value. There is no overflow: SUM_W covers NUM_CH*(2**WIDTH-1). In the first cycle after reset, sum=0.
- cnt latency: a change is visible one edge after the controlling inputs.
- All arithmetic is unsigned. Out-of-range internal values are unreachable.

Decomposition:
- Package counter_pkg:
  - typedef cnt_mode_e {CNT_WRAP, CNT_SAT}
  - function clamp_to_max(value, max)
  - localparam helper sum_width(width, nch)
- Sub-module counter_channel holds one channel's counter, load clamp, wrap/saturate logic and evt flag, with ports clk, rst, en, up, load, load_val, sat_mode, evt_clr, cnt, evt.
- multi_counter generates NUM_CH counter_channel instances plus the registered adder tree for sum.

Test Plan:
(All with WIDTH=4, NUM_CH=3, MAX_VAL=9.)
1. Reset, then en=3'b111, up=3'b111, sat_mode=0 for 12 cycles:
   - Each cnt goes 0..9, 0, 1, 2.
   - evt=3'b111 from the edge where cnt wraps 9 to 0.
   - sum lags cnt by one cycle; e.g. cnt=3 on all channels gives sum=9 on the next cycle.
2. sat_mode=1, ch0 loaded with 8, up=1, en=1 for 3 cycles:
   - ch0 gives 9, 9, 9.
   - evt[0] set on the second edge.
   - Then up=0 at cnt=0 in saturate mode holds 0.
3. load=3'b001 with load_val ch0=15:
   - cnt0=9 (clamped); evt[0] unchanged.
   - load and en asserted together with load_val=4: cnt0=4, not 5.
4. ch1 at 0, up=0, en=1, sat_mode=0:
   - cnt1=9 and evt[1]=1.
   - Then evt_clr=1 in the same cycle as a new wrap: evt[1] stays 1.
   - evt_clr=1 alone: evt[1]=0 next edge.
5. rst=1 while all channels are counting and evt is set:
   - Next edge gives cnt=0, evt=0, sum=0.
   - rst=1 together with load: load is ignored.
6. Channels at 9, 9, 9 held (en=0):
   - sum=27 (fits SUM_W=6).
   - Channels with independent en/up patterns stay mutually isolated.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and helpers for the multi-channel counter bank.
package counter_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    // Limit a value to the top of the counting range.
    function automatic logic [31:0] clamp_to_max(input logic [31:0] value,
                                                 input logic [31:0] max);
        return (value > max) ? max : value;
    endfunction

    // Width that can hold the sum of nch full-scale width-bit counters.
    function automatic int sum_width(input int width, input int nch);
        return width + $clog2(nch);
    endfunction

endpackage

// File: rtl/counter_channel.sv
// One up/down counter channel with load clamp, wrap/saturate bounds and a
// sticky flag that records any attempt to count past either bound.
module counter_channel
    import counter_pkg::*;
#(
    parameter int WIDTH   = 10,
    parameter int MAX_VAL = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             sat_mode,
    input  logic             evt_clr,
    output logic [WIDTH-1:0] cnt,
    output logic             evt
);

    localparam logic [WIDTH-1:0] MaxVal   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] One      = WIDTH'(1);
    localparam logic [31:0]      MaxVal32 = 32'(MAX_VAL);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             evt_q, evt_d;
    logic             hit;
    cnt_mode_e        mode;

    // Next count and flag: load beats enable, a bound hit beats a flag clear.
    always_comb begin
        cnt_d = cnt_q;
        evt_d = evt_q;
        hit   = 1'b0;
        mode  = sat_mode ? CNT_SAT : CNT_WRAP;
        if (load) begin
            cnt_d = WIDTH'(clamp_to_max(32'(load_val), MaxVal32));
        end else if (en) begin
            if (up) begin
                if (cnt_q == MaxVal) begin
                    hit   = 1'b1;
                    cnt_d = (mode == CNT_SAT) ? MaxVal : '0;
                end else begin
                    cnt_d = cnt_q + One;
                end
            end else begin
                if (cnt_q == '0) begin
                    hit   = 1'b1;
                    cnt_d = (mode == CNT_SAT) ? '0 : MaxVal;
                end else begin
                    cnt_d = cnt_q - One;
                end
            end
        end
        if (hit) begin
            evt_d = 1'b1;
        end else if (evt_clr) begin
            evt_d = 1'b0;
        end
    end

    // Channel state registers; reset overrides every other control.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            evt_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            evt_q <= evt_d;
        end
    end

    assign cnt = cnt_q;
    assign evt = evt_q;

endmodule

// File: rtl/multi_counter.sv
// Bank of independent counter channels with a registered sum of all channels.
module multi_counter
    import counter_pkg::*;
#(
    parameter  int WIDTH   = 10,
    parameter  int NUM_CH  = 2,
    parameter  int MAX_VAL = 2**WIDTH - 1,
    localparam int SUM_W   = sum_width(WIDTH, NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       up,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*WIDTH-1:0] load_val,
    input  logic                    sat_mode,
    input  logic                    evt_clr,
    output logic [NUM_CH*WIDTH-1:0] cnt,
    output logic [SUM_W-1:0]        sum,
    output logic [NUM_CH-1:0]       evt
);

    logic [SUM_W-1:0] sum_q, sum_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        counter_channel #(
            .WIDTH   (WIDTH),
            .MAX_VAL (MAX_VAL)
        ) u_channel (
            .clk      (clk),
            .rst      (rst),
            .en       (en[i]),
            .up       (up[i]),
            .load     (load[i]),
            .load_val (load_val[i*WIDTH +: WIDTH]),
            .sat_mode (sat_mode),
            .evt_clr  (evt_clr),
            .cnt      (cnt[i*WIDTH +: WIDTH]),
            .evt      (evt[i])
        );
    end

    // Add up the registered channel values; SUM_W is wide enough not to overflow.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum_d = sum_d + SUM_W'(cnt[i*WIDTH +: WIDTH]);
        end
    end

    // Sum register, giving the sum one cycle behind the channel values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: tb/tb_multi_counter.sv
// Directed and random checking of multi_counter against a behavioural model.
module tb_multi_counter;

    localparam int W    = 4;
    localparam int N    = 3;
    localparam int MAXV = 9;
    localparam int SW   = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  en;
    logic [N-1:0]  up;
    logic [N-1:0]  load;
    logic [N*W-1:0] load_val;
    logic          sat_mode;
    logic          evt_clr;
    logic [N*W-1:0] cnt;
    logic [SW-1:0] sum;
    logic [N-1:0]  evt;

    int mCnt[N];
    bit mEvt[N];
    int mSum;
    int testsRun  = 0;
    int failCount = 0;

    multi_counter #(
        .WIDTH   (W),
        .NUM_CH  (N),
        .MAX_VAL (MAXV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .sat_mode (sat_mode),
        .evt_clr  (evt_clr),
        .cnt      (cnt),
        .sum      (sum),
        .evt      (evt)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance the model by one edge using the inputs currently applied.
    task automatic modelEdge();
        int newSum;
        newSum = 0;
        for (int i = 0; i < N; i++) newSum += mCnt[i];
        for (int i = 0; i < N; i++) begin
            int c;
            int lv;
            bit hit;
            c   = mCnt[i];
            lv  = int'(load_val[i*W +: W]);
            hit = 0;
            if (load[i]) begin
                c = (lv > MAXV) ? MAXV : lv;
            end else if (en[i]) begin
                if (up[i]) begin
                    hit = (c == MAXV);
                    c   = sat_mode ? ((c + 1 > MAXV) ? MAXV : c + 1) : (c + 1) % (MAXV + 1);
                end else begin
                    hit = (c == 0);
                    c   = sat_mode ? ((c - 1 < 0) ? 0 : c - 1) : (c + MAXV) % (MAXV + 1);
                end
            end
            if (rst) begin
                mCnt[i] = 0;
                mEvt[i] = 0;
            end else begin
                mCnt[i] = c;
                if (hit) mEvt[i] = 1;
                else if (evt_clr) mEvt[i] = 0;
            end
        end
        mSum = rst ? 0 : newSum;
    endtask

    task automatic checkOutput();
        for (int i = 0; i < N; i++) begin
            checkVal($sformatf("cnt%0d", i), 32'(cnt[i*W +: W]), mCnt[i]);
            checkVal($sformatf("evt%0d", i), 32'(evt[i]), 32'(mEvt[i]));
        end
        checkVal("sum", 32'(sum), mSum);
    endtask

    // One clock step: model the edge, let the DUT take it, compare just after.
    task automatic applyStimulus();
        modelEdge();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        rst = 1'b1; en = '0; up = '0; load = '0; load_val = '0;
        sat_mode = 1'b0; evt_clr = 1'b0;
        for (int i = 0; i < N; i++) begin mCnt[i] = 0; mEvt[i] = 0; end
        mSum = 0;

        // Reset state
        applyStimulus();
        checkVal("rst_cnt", 32'(cnt), 0);
        checkVal("rst_sum", 32'(sum), 0);
        checkVal("rst_evt", 32'(evt), 0);
        rst = 1'b0;

        // All channels counting up in wrap mode for 12 edges
        en = 3'b111; up = 3'b111;
        for (int k = 0; k < 12; k++) applyStimulus();
        checkVal("wrap_cnt0", 32'(cnt[3:0]), 2);
        checkVal("wrap_evt", 32'(evt), 7);
        checkVal("wrap_sum_lag", 32'(sum), 3);

        // Clear flags, then saturate ch0 from a load of 8
        en = '0; evt_clr = 1'b1;
        applyStimulus();
        evt_clr = 1'b0; sat_mode = 1'b1;
        load = 3'b001; load_val = 12'h008; en = 3'b001; up = 3'b001;
        applyStimulus();
        load = '0;
        applyStimulus();
        checkVal("sat_evt0_first", 32'(evt[0]), 0);
        applyStimulus();
        checkVal("sat_evt0_second", 32'(evt[0]), 1);
        applyStimulus();
        checkVal("sat_cnt0_hold", 32'(cnt[3:0]), 9);
        load = 3'b001; load_val = 12'h000; en = '0;
        applyStimulus();
        load = '0; en = 3'b001; up = 3'b000;
        applyStimulus();
        checkVal("sat_cnt0_low", 32'(cnt[3:0]), 0);

        // Load clamp, then load beating enable
        en = '0; load = 3'b001; load_val = 12'h00F;
        applyStimulus();
        checkVal("clamp_cnt0", 32'(cnt[3:0]), 9);
        en = 3'b001; up = 3'b001; load_val = 12'h004;
        applyStimulus();
        checkVal("load_over_en", 32'(cnt[3:0]), 4);

        // ch1 wraps downward; set beats clear; clear alone clears
        load = 3'b010; load_val = 12'h000; en = '0; sat_mode = 1'b0;
        applyStimulus();
        load = '0; en = 3'b010; up = 3'b000;
        applyStimulus();
        checkVal("down_wrap_cnt1", 32'(cnt[7:4]), 9);
        checkVal("down_wrap_evt1", 32'(evt[1]), 1);
        load = 3'b010; en = '0;
        applyStimulus();
        load = '0; en = 3'b010; evt_clr = 1'b1;
        applyStimulus();
        checkVal("set_over_clr", 32'(evt[1]), 1);
        en = '0;
        applyStimulus();
        checkVal("clr_alone", 32'(evt[1]), 0);
        evt_clr = 1'b0;

        // Reset mid-operation overrides load
        en = 3'b111; up = 3'b111;
        for (int k = 0; k < 3; k++) applyStimulus();
        rst = 1'b1; load = 3'b111; load_val = 12'h555;
        applyStimulus();
        checkVal("rst_load_cnt", 32'(cnt), 0);
        checkVal("rst_load_evt", 32'(evt), 0);
        rst = 1'b0; load = '0;

        // Full-scale sum, then independent channel patterns
        en = '0; load = 3'b111; load_val = 12'h999;
        applyStimulus();
        load = '0;
        applyStimulus();
        checkVal("sum_full", 32'(sum), 27);
        en = 3'b101; up = 3'b001;
        for (int k = 0; k < 4; k++) applyStimulus();
        checkVal("isolate_cnt1", 32'(cnt[7:4]), 9);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            en       = N'($urandom);
            up       = N'($urandom);
            load     = N'($urandom_range(0, 7) == 0 ? $urandom : 0);
            load_val = (N*W)'($urandom);
            sat_mode = 1'($urandom);
            evt_clr  = ($urandom_range(0, 5) == 0);
            rst      = ($urandom_range(0, 60) == 0);
            applyStimulus();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
